// File: rtl/mmio_hub_pkg.sv
// ============================================================================
// mmio_hub_pkg : MMIO window offsets, TO_HOST status bits, register decode
// Rev 1.0
// ============================================================================
`default_nettype none

package mmio_hub_pkg;

  localparam logic [3:0]  MMIO_TAG       = 4'hf;

  localparam logic [15:0] MMIO_HALT      = 16'h0000;
  localparam logic [15:0] MMIO_TO_HOST   = 16'h0004;
  localparam logic [15:0] MMIO_LED       = 16'h0008;
  localparam logic [15:0] MMIO_SEG7      = 16'h000C;
  localparam logic [15:0] MMIO_BTN       = 16'h0010;
  localparam logic [15:0] MMIO_SW        = 16'h0014;
  localparam logic [15:0] MMIO_LFSR      = 16'h0018;
  localparam logic [15:0] MMIO_CPU_FREQ  = 16'h001C;
  localparam logic [15:0] MMIO_TXQ_LVL   = 16'h0020;
  localparam logic [15:0] MMIO_TIMER_LO  = 16'h0024;
  localparam logic [15:0] MMIO_TIMER_HI  = 16'h0028;
  localparam logic [15:0] MMIO_TIMER_CMP = 16'h002C;

  localparam int TOHOST_NOTFULL_BIT = 0;
  localparam int TOHOST_OVF_BIT     = 1;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_HALT,
    SEL_TO_HOST,
    SEL_LED,
    SEL_SEG7,
    SEL_BTN,
    SEL_SW,
    SEL_LFSR,
    SEL_CPU_FREQ,
    SEL_TXQ_LVL,
    SEL_TIMER_LO,
    SEL_TIMER_HI,
    SEL_TIMER_CMP
  } reg_sel_e;

  // Only exact word offsets select a register; anything else is unmapped.
  function automatic reg_sel_e mmio_decode(input logic [15:0] offs);
    case (offs)
      MMIO_HALT:      return SEL_HALT;
      MMIO_TO_HOST:   return SEL_TO_HOST;
      MMIO_LED:       return SEL_LED;
      MMIO_SEG7:      return SEL_SEG7;
      MMIO_BTN:       return SEL_BTN;
      MMIO_SW:        return SEL_SW;
      MMIO_LFSR:      return SEL_LFSR;
      MMIO_CPU_FREQ:  return SEL_CPU_FREQ;
      MMIO_TXQ_LVL:   return SEL_TXQ_LVL;
      MMIO_TIMER_LO:  return SEL_TIMER_LO;
      MMIO_TIMER_HI:  return SEL_TIMER_HI;
      MMIO_TIMER_CMP: return SEL_TIMER_CMP;
      default:        return SEL_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_hub_fifo.sv
// ============================================================================
// sync_byte_fifo : circular-buffer FIFO, extra pointer MSB separates full/empty
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign count_o = wptr_q - rptr_q;
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  assign w_do_pop  = pop_i && !empty_o;
  // A push into a full queue is still taken when the head leaves on the same edge.
  assign w_do_push = push_i && (!full_o || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (w_do_push) wptr_q <= wptr_q + 1'b1;
      if (w_do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/mmio_hub.sv
// ============================================================================
// mmio_hub : MMIO register hub with buffered UART TX; cycle timer when MMIO_TIMER_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module mmio_hub
  import mmio_hub_pkg::*;
#(
  parameter int          LED_W     = 16,
  parameter int          SW_W      = 16,
  parameter int          BTN_W     = 5,
  parameter int          TXQ_DEPTH = 16,
  parameter logic [31:0] CPU_FREQ  = 32'd60000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oe,
  input  logic [15:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       we,
  output logic [31:0]      rdata,
  output logic             valid,
  output logic             halt,
  output logic [LED_W-1:0] led,
  output logic [31:0]      seg7,
  input  logic [BTN_W-1:0] btn,
  input  logic [SW_W-1:0]  sw,
  input  logic [31:0]      rnd,
  output logic [7:0]       tx_data,
  output logic             tx_we,
  input  logic             tx_ready,
  output logic             timer_irq
);

  localparam int CNT_W = $clog2(TXQ_DEPTH) + 1;

  logic [31:0]      rdata_q;
  logic             valid_q;
  logic             halt_q;
  logic [LED_W-1:0] led_q;
  logic [31:0]      seg7_q;
  logic [7:0]       tx_data_q;
  logic             tx_we_q;
  logic             ovf_q;

  reg_sel_e         w_sel;
  logic             w_store;
  logic             w_load;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_head;
  logic [CNT_W-1:0] w_count;
  logic [31:0]      w_rd_val;
  logic             w_unused;

  assign w_sel   = mmio_decode(addr);
  assign w_store = oe && we[0];
  assign w_load  = oe && !we[0];
  assign w_push  = w_store && (w_sel == SEL_TO_HOST);
  // Skipping the cycle after a strobe lets UARTTX drop tx_ready before the next pop.
  assign w_pop   = !w_empty && tx_ready && !tx_we_q;
  assign w_unused = &{1'b0, we[3:1]};

  sync_byte_fifo #(
    .WIDTH (8),
    .DEPTH (TXQ_DEPTH)
  ) u_txq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .data_i  (wdata[7:0]),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

`ifdef MMIO_TIMER_EN
  logic [63:0] timer_q;
  logic [31:0] cmp_q;
  logic [31:0] hi_latch_q;
  logic        irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q    <= '0;
      cmp_q      <= 32'hFFFF_FFFF;
      hi_latch_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      timer_q <= timer_q + 64'd1;
      if (w_store && (w_sel == SEL_TIMER_CMP)) begin
        cmp_q <= wdata;
        irq_q <= 1'b0;
      end else if (timer_q[31:0] == cmp_q) begin
        irq_q <= 1'b1;
      end
      // Upper half is frozen with the low read so a LO/HI pair is coherent.
      if (w_load && (w_sel == SEL_TIMER_LO)) hi_latch_q <= timer_q[63:32];
    end
  end

  assign timer_irq = irq_q;
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    w_rd_val = '0;
    case (w_sel)
      SEL_TO_HOST: begin
        w_rd_val[TOHOST_OVF_BIT]     = ovf_q;
        w_rd_val[TOHOST_NOTFULL_BIT] = !w_full;
      end
      SEL_LED:       w_rd_val = 32'(led_q);
      SEL_SEG7:      w_rd_val = seg7_q;
      SEL_BTN:       w_rd_val = 32'(btn);
      SEL_SW:        w_rd_val = 32'(sw);
      SEL_LFSR:      w_rd_val = rnd;
      SEL_CPU_FREQ:  w_rd_val = CPU_FREQ;
      SEL_TXQ_LVL:   w_rd_val = 32'(w_count);
`ifdef MMIO_TIMER_EN
      SEL_TIMER_LO:  w_rd_val = timer_q[31:0];
      SEL_TIMER_HI:  w_rd_val = hi_latch_q;
      SEL_TIMER_CMP: w_rd_val = cmp_q;
`endif
      default:       w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      halt_q    <= 1'b0;
      led_q     <= '0;
      seg7_q    <= '0;
      tx_data_q <= '0;
      tx_we_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      valid_q <= w_load;
      if (w_load) rdata_q <= w_rd_val;
      if (w_store) begin
        case (w_sel)
          SEL_HALT:    halt_q <= 1'b1;
          SEL_LED:     led_q  <= wdata[LED_W-1:0];
          SEL_SEG7:    seg7_q <= wdata;
          SEL_TXQ_LVL: ovf_q  <= 1'b0;
          default:     ;
        endcase
      end
      if (w_push && w_full && !w_pop) ovf_q <= 1'b1;
      tx_we_q <= w_pop;
      if (w_pop) tx_data_q <= w_head;
    end
  end

  assign rdata   = rdata_q;
  assign valid   = valid_q;
  assign halt    = halt_q;
  assign led     = led_q;
  assign seg7    = seg7_q;
  assign tx_data = tx_data_q;
  assign tx_we   = tx_we_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_hub.sv
// ============================================================================
// tb_mmio_hub : directed + randomized bench with a queue-based UART byte model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mmio_hub;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        oe;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic [31:0] rdata;
  logic        valid;
  logic        halt;
  logic [15:0] led;
  logic [31:0] seg7;
  logic [4:0]  btn;
  logic [15:0] sw;
  logic [31:0] rnd;
  logic [7:0]  tx_data;
  logic        tx_we;
  logic        tx_ready;
  logic        timer_irq;

  int errors = 0;
  int checks = 0;

  byte unsigned    txq_m[$];
  int              tx_seen = 0;
  bit              prev_tx_we = 1'b0;
  longint unsigned tcnt = 0;

  mmio_hub #(
    .LED_W     (16),
    .SW_W      (16),
    .BTN_W     (5),
    .TXQ_DEPTH (DEPTH),
    .CPU_FREQ  (32'd60000000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .oe        (oe),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .rdata     (rdata),
    .valid     (valid),
    .halt      (halt),
    .led       (led),
    .seg7      (seg7),
    .btn       (btn),
    .sw        (sw),
    .rnd       (rnd),
    .tx_data   (tx_data),
    .tx_we     (tx_we),
    .tx_ready  (tx_ready),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  // Cycles since the last reset edge: what a free-running timer must show.
  always @(posedge clk) tcnt <= rst ? 64'd0 : tcnt + 64'd1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART side: every strobe must carry the oldest outstanding byte, never back-to-back.
  always @(negedge clk) begin
    if (tx_we === 1'b1) begin
      chk("tx_gap", 64'(prev_tx_we), 64'd0);
      if (txq_m.size() == 0) chk("tx_spurious", 64'(tx_we), 64'd0);
      else                   chk("tx_data", 64'(tx_data), 64'(txq_m.pop_front()));
      tx_seen++;
    end
    prev_tx_we = (tx_we === 1'b1);
  end

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 4'b0001; oe = 1'b1;
    @(posedge clk); #1;
    oe = 1'b0; we = 4'b0000;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp, input string tag);
    addr = a; we = 4'b0000; oe = 1'b1;
    @(posedge clk); #1;
    oe = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, 64'(valid), 64'd1);
    chk(tag, 64'(rdata), 64'(exp));
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] b, input bit accepted);
    wr(16'h0004, {$urandom_range(0, 255), 16'h0, b} & 32'hFF0000FF);
    if (accepted) txq_m.push_back(b);
  endtask

  task automatic drain(input string tag);
    tx_ready = 1'b1;
    for (int i = 0; i < 200 && txq_m.size() != 0; i++) @(posedge clk);
    #1;
    chk(tag, 64'(txq_m.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]     d;
    logic [15:0]     led_m;
    logic [31:0]     seg_m;
    int              seen0;

    rst = 1'b1; oe = 1'b0; addr = '0; wdata = '0; we = '0;
    btn = '0; sw = '0; rnd = '0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values and first-load latency
    @(negedge clk);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_halt", 64'(halt), 64'd0);
    chk("rst_led", 64'(led), 64'd0);
    chk("rst_seg7", 64'(seg7), 64'd0);
    chk("rst_tx_we", 64'(tx_we), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_irq", 64'(timer_irq), 64'd0);
    @(posedge clk); #1;
    rd(16'h0008, 32'h0, "led_rst");
    rd(16'h000C, 32'h0, "seg7_rst");
    rd(16'h0004, 32'h1, "tohost_rst");
    rd(16'h0020, 32'h0, "txqlvl_rst");
    @(negedge clk);
    chk("valid_idle", 64'(valid), 64'd0);
    @(posedge clk); #1;

    // Register file, HALT, unmapped offsets
    wr(16'h0008, 32'h1234_A5A5);
    led_m = 16'hA5A5;
    chk("led_port", 64'(led), 64'h A5A5);
    rd(16'h0008, 32'h0000_A5A5, "led_rd");
    wr(16'h000C, 32'hDEAD_BEEF);
    seg_m = 32'hDEAD_BEEF;
    rd(16'h000C, 32'hDEAD_BEEF, "seg7_rd");
    chk("halt_pre", 64'(halt), 64'd0);
    wr(16'h0000, 32'h0);
    chk("halt_set", 64'(halt), 64'd1);
    wr(16'h0030, 32'hFFFF_FFFF);
    wr(16'h0009, 32'h0000_0000);
    rd(16'h0030, 32'h0, "unmapped_rd");
    // we[0]=0 with upper enables set is a load, not a store
    addr = 16'h0008; wdata = 32'h0; we = 4'b1110; oe = 1'b1;
    @(posedge clk); #1;
    oe = 1'b0; we = 4'b0000;
    chk("we_hi_no_store", 64'(led), 64'h A5A5);
    chk("we_hi_load_data", 64'(rdata), 64'h0000_A5A5);
    rd(16'h001C, 32'd60000000, "cpu_freq");

    // Back-to-back pushes with an always-ready UART
    tx_ready = 1'b1;
    seen0 = tx_seen;
    push(8'h41, 1'b1);
    push(8'h42, 1'b1);
    push(8'h43, 1'b1);
    for (int i = 0; i < 20 && txq_m.size() != 0; i++) @(posedge clk);
    #1;
    chk("three_pulses", 64'(tx_seen - seen0), 64'd3);
    repeat (2) @(posedge clk); #1;

    // Fill past capacity with the UART stalled
    tx_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) push(8'(8'h60 + i), i < DEPTH);
    rd(16'h0020, 32'd16, "lvl_full");
    rd(16'h0004, 32'h2, "tohost_ovf");
    wr(16'h0020, 32'h0);
    rd(16'h0004, 32'h0, "tohost_ovf_clr");

    // Push coinciding with a pop on a full queue
    tx_ready = 1'b1;
    push(8'h99, 1'b1);
    tx_ready = 1'b0;
    rd(16'h0020, 32'd16, "lvl_push_pop");
    rd(16'h0004, 32'h0, "tohost_no_ovf");
    drain("drain_full");
    rd(16'h0020, 32'h0, "lvl_drained");

    // Randomized traffic against the byte-queue and register models
    for (int it = 0; it < 80; it++) begin
      tx_ready = 1'($urandom_range(0, 1));
      btn = 5'($urandom);
      sw  = 16'($urandom);
      rnd = $urandom;
      case ($urandom_range(0, 6))
        0: begin d = $urandom; wr(16'h0008, d); led_m = d[15:0]; end
        1: rd(16'h0008, {16'h0, led_m}, "rand_led");
        2: begin d = $urandom; wr(16'h000C, d); seg_m = d; end
        3: rd(16'h000C, seg_m, "rand_seg7");
        4: begin
          case ($urandom_range(0, 2))
            0:       rd(16'h0010, {27'h0, btn}, "rand_btn");
            1:       rd(16'h0014, {16'h0, sw}, "rand_sw");
            default: rd(16'h0018, rnd, "rand_lfsr");
          endcase
        end
        5: if (txq_m.size() < DEPTH) push(8'($urandom), 1'b1);
        default: begin
          chk("rand_led_port", 64'(led), 64'(led_m));
          chk("rand_seg7_port", 64'(seg7), 64'(seg_m));
          @(posedge clk); #1;
        end
      endcase
    end
    drain("drain_rand");
    chk("halt_sticky", 64'(halt), 64'd1);

    // Reset mid-run, then timer behaviour
    tx_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    txq_m.delete();
    chk("halt_cleared", 64'(halt), 64'd0);
    chk("led_cleared", 64'(led), 64'd0);
    rd(16'h0020, 32'h0, "lvl_after_rst");
`ifdef MMIO_TIMER_EN
    rd(16'h002C, 32'hFFFF_FFFF, "cmp_rst");
    for (int i = 0; i < 20 && tcnt < 9; i++) @(posedge clk);
    #1;
    wr(16'h002C, 32'd100);
    for (int i = 0; i < 200 && tcnt < 106; i++) begin
      @(negedge clk);
      if (tcnt >= 95) chk("irq_edge", 64'(timer_irq), 64'(tcnt >= 101));
    end
    @(posedge clk); #1;
    d = 32'(tcnt);
    rd(16'h0024, d, "timer_lo");
    rd(16'h0028, 32'h0, "timer_hi");
    wr(16'h002C, 32'h0010_0000);
    chk("irq_clr", 64'(timer_irq), 64'd0);
    rd(16'h002C, 32'h0010_0000, "cmp_rd");
`else
    rd(16'h0024, 32'h0, "timer_lo_unmapped");
    rd(16'h0028, 32'h0, "timer_hi_unmapped");
    wr(16'h002C, 32'd5);
    rd(16'h002C, 32'h0, "timer_cmp_unmapped");
    repeat (10) @(posedge clk);
    #1;
    chk("irq_tied", 64'(timer_irq), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
